// File: rtl/cpu_bus_seq_pkg.sv
// Shared definitions for the byte-bus sequencer: operand size codes, FSM states
// and the bytes-per-size helper.
package cpu_bus_seq_pkg;

  typedef enum logic [1:0] {
    BUS_SZ_8    = 2'd0,
    BUS_SZ_16   = 2'd1,
    BUS_SZ_32   = 2'd2,
    BUS_SZ_RSVD = 2'd3
  } bus_size_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // A return value of 0 marks the reserved encoding.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (bus_size_e'(sz))
      BUS_SZ_8:  return 3'd1;
      BUS_SZ_16: return 3'd2;
      BUS_SZ_32: return 3'd4;
      default:   return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_bus_seq_if.sv
// Operand-side request/response and byte-bus signals of the sequencer, grouped
// so the CPU and bus sides can be bound with one port.
interface cpu_bus_seq_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
  // Handshake: i_req is looked at only while the sequencer is idle and is
  // neither queued nor remembered otherwise; o_done pulses once per accepted
  // request with o_err qualifying it. On the byte bus, address/we/data become
  // stable one cycle before o_bus_clk rises, stay stable while it is high, and
  // the first rising clock edge that sees i_bus_data_ready high completes the byte.
  logic              i_req;
  logic              i_we;
  logic [1:0]        i_size;
  logic              i_wrap_pg;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_wdata;
  logic              o_busy;
  logic              o_done;
  logic              o_err;
  logic [DATA_W-1:0] o_rdata;
  logic              o_bus_clk;
  logic              o_bus_we;
  logic [ADDR_W-1:0] o_bus_addr;
  logic [7:0]        o_bus_data;
  logic [7:0]        i_bus_data;
  logic              i_bus_data_ready;

  modport slave (
    input  i_req, i_we, i_size, i_wrap_pg, i_addr, i_wdata, i_bus_data, i_bus_data_ready,
    output o_busy, o_done, o_err, o_rdata, o_bus_clk, o_bus_we, o_bus_addr, o_bus_data
  );

  modport master (
    output i_req, i_we, i_size, i_wrap_pg, i_addr, i_wdata, i_bus_data, i_bus_data_ready,
    input  o_busy, o_done, o_err, o_rdata, o_bus_clk, o_bus_we, o_bus_addr, o_bus_data
  );

endinterface

// File: rtl/cpu_bus_seq_addr_step.sv
// Byte address generator: base + offset, either linear over the full address
// space or wrapping inside the 256-byte page of the base (6502 ZP/indirect rule).
module cpu_bus_seq_addr_step #(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] i_base,
    input  logic [7:0]        i_off,
    input  logic              i_wrap,
    output logic [ADDR_W-1:0] o_addr
);

  logic [ADDR_W-1:0] lin_addr;
  logic [7:0]        pg_low;

  assign lin_addr = i_base + {{(ADDR_W-8){1'b0}}, i_off};
  assign pg_low   = i_base[7:0] + i_off;
  assign o_addr   = i_wrap ? {i_base[ADDR_W-1:8], pg_low} : lin_addr;

endmodule

// File: rtl/cpu_bus_seq.sv
// Splits one 8/16/32-bit little-endian operand access into byte transfers on the
// external strobe/ready bus. Optional WAIT timeout: define CPU_BUS_TIMEOUT_EN.
module cpu_bus_seq
  import cpu_bus_seq_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255,
    localparam int TMO_W      = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic             i_cpu_clk,
    input  logic             i_rst,
    cpu_bus_seq_if.slave     bus,
    output state_t           o_dbg_state,
    output logic [TMO_W-1:0] o_dbg_wait_cnt
);

  localparam logic [2:0] MAX_BYTES = 3'(DATA_W / 8);

  state_t            state_q;
  logic              we_q;
  logic              wrap_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [2:0]        nbytes_q;
  logic [1:0]        k_q;
  logic              err_q;
  logic              busy_q;
  logic              done_q;
  logic              err_out_q;
  logic [DATA_W-1:0] rdata_q;
  logic              bus_clk_q;
  logic              bus_we_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [7:0]        bus_data_q;
  logic [TMO_W-1:0]  wait_cnt_q;

  logic [2:0]        req_bytes;
  logic              req_bad;
  logic [ADDR_W-1:0] addr_k;
  logic [7:0]        wbyte_k;
  logic              k_last;

  assign req_bytes = size_bytes(bus.i_size);
  assign req_bad   = (req_bytes == 3'd0) || (req_bytes > MAX_BYTES);
  assign wbyte_k   = 8'(wdata_q >> {k_q, 3'b000});
  assign k_last    = (k_q == 2'(nbytes_q - 3'd1));

  cpu_bus_seq_addr_step #(.ADDR_W(ADDR_W)) u_addr_step (
    .i_base (addr_q),
    .i_off  ({6'd0, k_q}),
    .i_wrap (wrap_q),
    .o_addr (addr_k)
  );

  always_ff @(posedge i_cpu_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      we_q       <= 1'b0;
      wrap_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      nbytes_q   <= '0;
      k_q        <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_out_q  <= 1'b0;
      rdata_q    <= '0;
      bus_clk_q  <= 1'b0;
      bus_we_q   <= 1'b0;
      bus_addr_q <= '0;
      bus_data_q <= '0;
      wait_cnt_q <= '0;
    end else begin
      done_q    <= 1'b0;
      err_out_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.i_req) begin
            we_q     <= bus.i_we;
            wrap_q   <= bus.i_wrap_pg;
            addr_q   <= bus.i_addr;
            wdata_q  <= bus.i_wdata;
            nbytes_q <= req_bytes;
            k_q      <= '0;
            busy_q   <= 1'b1;
            err_q    <= req_bad;
            if (!bus.i_we) rdata_q <= '0;
            state_q  <= req_bad ? ST_DONE : ST_SETUP;
          end
        end
        ST_SETUP: begin
          bus_addr_q <= addr_k;
          bus_we_q   <= we_q;
          bus_data_q <= wbyte_k;
          bus_clk_q  <= 1'b0;
          state_q    <= ST_STROBE;
        end
        ST_STROBE: begin
          bus_clk_q  <= 1'b1;
          wait_cnt_q <= '0;
          state_q    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.i_bus_data_ready) begin
            // rdata was cleared at accept, so OR-ing each byte in zero-extends.
            if (!we_q) rdata_q <= rdata_q | (DATA_W'(bus.i_bus_data) << {k_q, 3'b000});
            bus_clk_q <= 1'b0;
            if (k_last) begin
              state_q <= ST_DONE;
            end else begin
              k_q     <= k_q + 2'd1;
              state_q <= ST_SETUP;
            end
          end
`ifdef CPU_BUS_TIMEOUT_EN
          else if (wait_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
            bus_clk_q <= 1'b0;
            err_q     <= 1'b1;
            state_q   <= ST_DONE;
          end
`endif
          else if (wait_cnt_q != TMO_W'(TIMEOUT_CYC)) begin
            wait_cnt_q <= wait_cnt_q + TMO_W'(1);
          end
        end
        ST_DONE: begin
          done_q    <= 1'b1;
          err_out_q <= err_q;
          bus_we_q  <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_busy     = busy_q;
  assign bus.o_done     = done_q;
  assign bus.o_err      = err_out_q;
  assign bus.o_rdata    = rdata_q;
  assign bus.o_bus_clk  = bus_clk_q;
  assign bus.o_bus_we   = bus_we_q;
  assign bus.o_bus_addr = bus_addr_q;
  assign bus.o_bus_data = bus_data_q;
  assign o_dbg_state    = state_q;
  assign o_dbg_wait_cnt = wait_cnt_q;

endmodule

// File: tb/tb_cpu_bus_seq.sv
// Bench for cpu_bus_seq: directed cases plus random accesses against a
// transaction-level model of addresses, byte order, latency and read results.
module tb_cpu_bus_seq;
  import cpu_bus_seq_pkg::*;

`ifdef CPU_BUS_TIMEOUT_EN
  localparam int TB_TMO = 4;
`else
  localparam int TB_TMO = 255;
`endif
  localparam int TB_TMO_W = $clog2(TB_TMO + 1);

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  cpu_bus_seq_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();
  state_t                dbg_state;
  logic [TB_TMO_W-1:0]   dbg_wait_cnt;

  cpu_bus_seq #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TB_TMO)) dut (
    .i_cpu_clk      (clk),
    .i_rst          (rst),
    .bus            (bus_if.slave),
    .o_dbg_state    (dbg_state),
    .o_dbg_wait_cnt (dbg_wait_cnt)
  );

  // ---------------- scoreboard ----------------
  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  exp_byte_q[$];
  logic [31:0] model_rdata = 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus_if.i_req            = 1'b0;
    bus_if.i_we             = 1'b0;
    bus_if.i_size           = 2'd0;
    bus_if.i_wrap_pg        = 1'b0;
    bus_if.i_addr           = 32'h0;
    bus_if.i_wdata          = 32'h0;
    bus_if.i_bus_data       = 8'h0;
    bus_if.i_bus_data_ready = 1'b0;
  endtask

  // One access from request to completion; the bench acts as the byte-bus
  // slave, raising ready dly cycles after it first sees the strobe high.
  task automatic run_access(input logic we, input logic [1:0] size, input logic wrap,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rb, input int dly);
    int          nb, lat, c, wcnt, nstrobe;
    logic        exp_err;
    logic [31:0] a;
    nb      = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
    exp_err = (nb == 0);
    exp_q.delete();
    exp_byte_q.delete();
    for (int i = 0; i < nb; i++) begin
      a = wrap ? ((addr & 32'hFFFF_FF00) | ((addr + i) & 32'h0000_00FF)) : addr + i;
      exp_q.push_back(a);
      exp_byte_q.push_back(we ? 8'(wdata >> (8 * i)) : 8'(rb >> (8 * i)));
    end
    if (!we) begin
      model_rdata = 32'h0;
      for (int i = 0; i < nb; i++) model_rdata = model_rdata | (rb & (32'hFF << (8 * i)));
    end
    lat = exp_err ? 1 : nb * (3 + dly) + 1;

    @(negedge clk);
    bus_if.i_req = 1'b1; bus_if.i_we = we; bus_if.i_size = size;
    bus_if.i_wrap_pg = wrap; bus_if.i_addr = addr; bus_if.i_wdata = wdata;
    @(posedge clk); #1;
    check("busy_at_accept", bus_if.o_busy, 1);
    check("done_at_accept", bus_if.o_done, 0);
    c = 0; wcnt = 0; nstrobe = 0;
    while (c < lat) begin
      // Noise on the request side while busy must be ignored.
      bus_if.i_req  = ((c + 1) < lat) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus_if.i_addr = $urandom; bus_if.i_wdata = $urandom;
      bus_if.i_we   = 1'($urandom_range(0, 1)); bus_if.i_size = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
      c++;
      check("busy", bus_if.o_busy, 32'(c < lat));
      check("done", bus_if.o_done, 32'(c == lat));
      if (c == lat) begin
        check("err", bus_if.o_err, exp_err);
        check("rdata", bus_if.o_rdata, model_rdata);
        check("bus_clk_end", bus_if.o_bus_clk, 0);
        check("bus_we_end", bus_if.o_bus_we, 0);
        check("strobe_cnt", nstrobe, nb);
      end
      if (bus_if.o_bus_clk) begin
        if (exp_q.size() == 0) begin
          check("strobe_cnt", nstrobe + 1, nb);
          bus_if.i_bus_data_ready = 1'b0;
        end else begin
          check("bus_addr", bus_if.o_bus_addr, exp_q[0]);
          check("bus_we", bus_if.o_bus_we, we);
          if (we) check("bus_data", bus_if.o_bus_data, exp_byte_q[0]);
          wcnt++;
          if (wcnt > dly) begin
            bus_if.i_bus_data_ready = 1'b1;
            bus_if.i_bus_data       = exp_byte_q[0];
            void'(exp_q.pop_front());
            void'(exp_byte_q.pop_front());
            nstrobe++;
            wcnt = 0;
          end else begin
            bus_if.i_bus_data_ready = 1'b0;
          end
        end
      end else begin
        bus_if.i_bus_data_ready = 1'b0;
      end
    end
    bus_if.i_req = 1'b0;
    bus_if.i_bus_data_ready = 1'b0;
    @(posedge clk); #1;
    check("done_one_cycle", bus_if.o_done, 0);
    check("busy_after", bus_if.o_busy, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] r;
    int          sz;
    drive_idle();
    rst = 1'b1;
    #1;
    check("rst_busy", bus_if.o_busy, 0);
    check("rst_done", bus_if.o_done, 0);
    check("rst_bus_clk", bus_if.o_bus_clk, 0);
    check("rst_bus_addr", bus_if.o_bus_addr, 0);
    check("rst_rdata", bus_if.o_rdata, 0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    run_access(1'b0, 2'd2, 1'b0, 32'h0000_12FE, 32'h0, 32'h4433_2211, 0);
    check("rd32_value", bus_if.o_rdata, 32'h4433_2211);
    run_access(1'b0, 2'd1, 1'b1, 32'h0000_00FF, 32'h0, $urandom, 0);
    run_access(1'b1, 2'd1, 1'b0, 32'h0000_0200, 32'h0000_BEEF, 32'h0, 2);
    run_access(1'b1, 2'd3, 1'b0, 32'h0000_0300, 32'h1234_5678, 32'h0, 0);
    run_access(1'b0, 2'd3, 1'b0, 32'h0000_0300, 32'h0, $urandom, 0);
    run_access(1'b0, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'h0, $urandom, 1);
    run_access(1'b1, 2'd2, 1'b1, 32'h0000_04FD, 32'hCAFE_F00D, 32'h0, 0);

    // Reset during WAIT of byte 1 of a 32-bit read.
    @(negedge clk);
    bus_if.i_req = 1'b1; bus_if.i_we = 1'b0; bus_if.i_size = 2'd2;
    bus_if.i_wrap_pg = 1'b0; bus_if.i_addr = 32'h0000_7000;
    bus_if.i_bus_data = 8'h5A; bus_if.i_bus_data_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.i_req = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid_bus_clk", bus_if.o_bus_clk, 1);
    check("mid_bus_addr", bus_if.o_bus_addr, 32'h0000_7001);
    bus_if.i_bus_data_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("arst_busy", bus_if.o_busy, 0);
    check("arst_done", bus_if.o_done, 0);
    check("arst_err", bus_if.o_err, 0);
    check("arst_bus_clk", bus_if.o_bus_clk, 0);
    check("arst_bus_we", bus_if.o_bus_we, 0);
    check("arst_bus_addr", bus_if.o_bus_addr, 0);
    check("arst_bus_data", bus_if.o_bus_data, 0);
    check("arst_rdata", bus_if.o_rdata, 0);
    model_rdata = 32'h0;
    repeat (3) begin
      @(posedge clk); #1;
      check("arst_no_done", bus_if.o_done, 0);
    end
    @(negedge clk) rst = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      check("post_rst_no_done", bus_if.o_done, 0);
      check("post_rst_idle", bus_if.o_busy, 0);
    end
    run_access(1'b0, 2'd0, 1'b0, 32'h0000_0042, 32'h0, 32'h0000_00A5, 0);

    // Random accesses.
    for (int t = 0; t < 40; t++) begin
      r  = $urandom;
      sz = $urandom_range(0, 8);
      case ($urandom_range(0, 2))
        0:       r = $urandom;
        1:       r = (r & 32'hFFFF_FF00) | 32'(8'hFC + 8'($urandom_range(0, 3)));
        default: r = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      endcase
      run_access(1'($urandom_range(0, 1)), (sz == 8) ? 2'd3 : 2'(sz % 3),
                 1'($urandom_range(0, 1)), r, $urandom, $urandom, $urandom_range(0, 2));
    end

`ifdef CPU_BUS_TIMEOUT_EN
    // Ready never comes: abort after TB_TMO WAIT cycles.
    @(negedge clk);
    bus_if.i_req = 1'b1; bus_if.i_we = 1'b0; bus_if.i_size = 2'd2;
    bus_if.i_wrap_pg = 1'b0; bus_if.i_addr = 32'h0000_9000; bus_if.i_bus_data_ready = 1'b0;
    @(posedge clk); #1;
    bus_if.i_req = 1'b0;
    for (int c = 1; c <= TB_TMO + 3; c++) begin
      @(posedge clk); #1;
      check("tmo_done", bus_if.o_done, 32'(c == TB_TMO + 3));
      check("tmo_busy", bus_if.o_busy, 32'(c < TB_TMO + 3));
      if (c == TB_TMO + 3) begin
        check("tmo_err", bus_if.o_err, 1);
        check("tmo_bus_clk", bus_if.o_bus_clk, 0);
        check("tmo_rdata", bus_if.o_rdata, 0);
      end
    end
`endif

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
